// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: LANES inverse S-boxes reused over N=16/LANES cycles.
// Ports: clk, rst_n (async low), in_valid/in_ready/in_data, out_valid/out_ready/out_data, busy.
module inv_sub_bytes_iter #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int N  = 16 / LANES;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int CB = LANES * 8;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [127:0]  src;
   logic [127:0]  res;
   logic [CB-1:0] chunk_in;
   logic [CB-1:0] chunk_out;

   function automatic logic [7:0] gf_mul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1b);
      end
      return p;
   endfunction

   // a^254 == a^-1 in GF(2^8); maps 0 to 0 as AES requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] s;
      logic [7:0] r;
      s = a;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r;
   endfunction

   // inverse affine transform, then field inversion
   function automatic logic [7:0] inv_sbox(input logic [7:0] s);
      logic [7:0] t;
      t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      return gf_inv(t);
   endfunction

   always_comb begin
      chunk_in  = src[int'(cnt)*CB +: CB];
      chunk_out = '0;
      for (int l = 0; l < LANES; l++) begin
         chunk_out[l*8 +: 8] = inv_sbox(chunk_in[l*8 +: 8]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         src       <= '0;
         res       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  src      <= in_data;
                  cnt      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               res[int'(cnt)*CB +: CB] <= chunk_out;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(N - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   assign out_data = res;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter at LANES = 1, 4 and 16.
// Reference S-boxes are built from GF(2^8) brute-force inversion and the forward affine map.
module tb_inv_sub_bytes_iter;

   localparam int ND = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid  [ND];
   logic         in_ready  [ND];
   logic         out_valid [ND];
   logic         out_ready [ND];
   logic         busy      [ND];
   logic [127:0] in_data   [ND];
   logic [127:0] out_data  [ND];

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : (g == 1) ? 4 : 16;
      inv_sub_bytes_iter #(.LANES(L)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid[g]),
         .in_ready  (in_ready[g]),
         .in_data   (in_data[g]),
         .out_valid (out_valid[g]),
         .out_ready (out_ready[g]),
         .out_data  (out_data[g]),
         .busy      (busy[g])
      );
   end

   int errors = 0;
   int checks = 0;

   logic [7:0] sbox  [256];
   logic [7:0] isbox [256];

   typedef struct {
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;

   function automatic int lanes(input int d);
      return (d == 0) ? 1 : (d == 1) ? 4 : 16;
   endfunction

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] m_rotl(input logic [7:0] x, input int n);
      logic [15:0] t;
      t = {x, x} << n;
      return t[15:8];
   endfunction

   function automatic logic [127:0] fwd_block(input logic [127:0] b);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[k*8 +: 8] = sbox[b[k*8 +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] inv_block(input logic [127:0] b);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[k*8 +: 8] = isbox[b[k*8 +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic build_model();
      logic [7:0] inv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         for (int y = 1; y < 256; y++)
            if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3) ^ m_rotl(inv, 4) ^ 8'h63;
         sbox[x]  = s;
         isbox[s] = 8'(x);
      end
   endtask

   task automatic do_block(input int d, input logic [127:0] din, input logic [127:0] exp,
                           input int gap, input int hold, input string tag);
      int t;
      int lat;
      int n;
      n = 16 / lanes(d);
      @(negedge clk);
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid[d] = 1'b1;
      in_data[d]  = din;
      t = 0;
      while (!in_ready[d] && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready[d]) begin
         chk({tag, " accept timeout"}, 0, 1);
         in_valid[d] = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid[d]  = 1'b0;
      in_data[d]   = rnd128();
      out_ready[d] = (hold == 0);
      chk({tag, " in_ready after accept"}, in_ready[d], 0);
      chk({tag, " busy after accept"}, busy[d], 1);
      lat = 0;
      while (!out_valid[d] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, lat, n);
      if (!out_valid[d]) return;
      for (int i = 0; i < hold; i++) begin
         chk({tag, " held data"}, out_data[d], exp);
         chk({tag, " held in_ready"}, in_ready[d], 0);
         in_valid[d] = 1'($urandom_range(0, 1));
         in_data[d]  = rnd128();
         @(negedge clk);
         chk({tag, " held out_valid"}, out_valid[d], 1);
      end
      in_valid[d] = 1'b0;
      chk({tag, " out_data"}, out_data[d], exp);
      out_ready[d] = 1'b1;
      @(negedge clk);
      out_ready[d] = 1'b0;
      chk({tag, " out_valid after hs"}, out_valid[d], 0);
      chk({tag, " in_ready after hs"}, in_ready[d], 1);
      chk({tag, " busy after hs"}, busy[d], 0);
   endtask

   vec_t       vecs [4];
   logic [7:0] perm [256];

   initial begin
      logic [127:0] orig;
      logic [7:0]   tmp;
      int           j;

      for (int d = 0; d < ND; d++) begin
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b0;
         in_data[d]   = '0;
      end
      build_model();

      vecs[0] = '{128'h76abd7fe2b670130c56f6bf27b777c63,
                  128'h0f0e0d0c0b0a09080706050403020100};
      vecs[1] = '{{16{8'h63}}, {16{8'h00}}};
      vecs[2] = '{{16{8'h00}}, {16{8'h52}}};
      vecs[3] = '{{16{8'h16}}, {16{8'hff}}};

      // asynchronous reset away from any edge
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("reset in_ready d%0d", d), in_ready[d], 1);
         chk($sformatf("reset out_valid d%0d", d), out_valid[d], 0);
         chk($sformatf("reset busy d%0d", d), busy[d], 0);
         chk($sformatf("reset out_data d%0d", d), out_data[d], 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++)
         do_block(1, vecs[i].din, vecs[i].dout, 0, 0, $sformatf("vec%0d", i));

      do_block(1, fwd_block(vecs[0].dout), vecs[0].dout, 0, 10, "backpressure");

      // reset after RUN edge E2, then a fresh block
      @(negedge clk);
      in_valid[1] = 1'b1;
      in_data[1]  = rnd128();
      chk("midrun ready", in_ready[1], 1);
      @(posedge clk);
      #1 in_valid[1] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun in_ready", in_ready[1], 1);
      chk("midrun out_valid", out_valid[1], 0);
      chk("midrun busy", busy[1], 0);
      chk("midrun out_data", out_data[1], 0);
      @(negedge clk);
      rst_n = 1'b1;
      orig = rnd128();
      do_block(1, fwd_block(orig), orig, 1, 2, "after reset");

      for (int d = 0; d < ND; d++) begin
         for (int i = 0; i < 256; i++) perm[i] = 8'(i);
         for (int i = 255; i > 0; i--) begin
            j       = int'($urandom_range(0, i));
            tmp     = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
         end
         for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < 16; k++) orig[k*8 +: 8] = perm[b*16 + k];
            chk($sformatf("model d%0d b%0d", d, b), inv_block(fwd_block(orig)), orig);
            do_block(d, fwd_block(orig), orig, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), $sformatf("rt d%0d b%0d", d, b));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
